vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single Avalon-MM slave port of the VGA text-mode controller (VRAM at word addresses 0x000–0x257, palette/control registers at ADDR[11]=1) between several on-chip masters, e.g. the CPU bridge and the hardware board painter. It arbitrates round-robin, one transaction per cycle, and registers the winning command onto the slave port. It routes read data back to the issuing requester and supports a bounded lock for atomic multi-word repaints.

## Interface
Parameters:
- NREQ, 2, number of requesters (2–4)
- READ_LATENCY, 2, slave cycles from registered read command to valid AVL_READDATA
- LOCK_MAX, 64, maximum granted transactions per lock tenure

Ports:
- CLK  in  1  system clock (50 MHz, same clock as VGA controller)
- RESET  in  1  asynchronous, active-high reset
- REQ_READ  in  NREQ  per-requester read strobe
- REQ_WRITE  in  NREQ  per-requester write strobe
- REQ_LOCK  in  NREQ  per-requester lock request
- REQ_ADDR  in  NREQ*12  packed addresses, requester i at [12i+11:12i]
- REQ_WRITEDATA  in  NREQ*32  packed write data
- REQ_BYTE_EN  in  NREQ*4  packed byte enables
- REQ_WAITREQUEST  out  NREQ  high = command not accepted this cycle
- REQ_READDATA  out  32  shared read-return bus
- REQ_READDATAVALID  out  NREQ  one-hot read-return qualifier
- AVL_READ, AVL_WRITE, AVL_CS  out  1 each  slave command
- AVL_ADDR  out  12, AVL_WRITEDATA  out  32, AVL_BYTE_EN  out  4
- AVL_READDATA  in  32  slave read data

## Operation
- Active requester: REQ_READ[i] | REQ_WRITE[i]. Both high: treat as write, drop read.
- Round-robin: search starts at (last_grant+1) mod NREQ; winner gets REQ_WAITREQUEST[i]=0 this cycle, all others 1. last_grant updates only on a grant.
- Requester holds command stable until its waitrequest is low.
- Accepted command registered to AVL_*; AVL_CS = AVL_READ | AVL_WRITE. No grant → AVL_READ/WRITE/CS = 0 next cycle, other AVL_* hold previous values.
- Read tracker: shift register depth 1+READ_LATENCY carrying {valid, id}; at exit, REQ_READDATA = AVL_READDATA, REQ_READDATAVALID = onehot(id). Up to one read per cycle in flight, so no overflow.
- Lock FSM:
  - ARB: normal round-robin. Granting requester i with REQ_LOCK[i]=1 → LOCKED, owner=i, count=1.
  - LOCKED: only owner eligible. count increments per owner grant. REQ_LOCK[owner]=0 → ARB. count reaches LOCK_MAX on a grant → COOLDOWN, last_grant=owner.
  - COOLDOWN: round-robin with owner excluded until REQ_LOCK[owner]=0, then → ARB.
- Owner idle while LOCKED (no read/write) → no grants issued; lock is held.
- Reset mid-operation: in-flight reads discarded, no REQ_READDATAVALID for them; FSM → ARB.

## Timing
- Reset values: REQ_WAITREQUEST all 1 while RESET is high; AVL_READ/WRITE/CS 0; AVL_ADDR/WRITEDATA/BYTE_EN 0; REQ_READDATAVALID 0; REQ_READDATA 0; last_grant = NREQ-1, so requester 0 has first priority; state ARB; count 0.
- Grant combinational from requests, last_grant and state in cycle N. Command is on AVL_* in cycle N+1.
- Read issued in N: REQ_READDATAVALID in N+1+READ_LATENCY (default N+3).
- Throughput: one transaction per cycle. Back-to-back grants to the same requester are allowed when it is the only active one.
- count width: clog2(LOCK_MAX+1), saturating; never wraps.

## Structure
- Package vram_arb_pkg: lock state enum (ARB, LOCKED, COOLDOWN), AVL_ADDR_W=12, AVL_DATA_W=32, AVL_BE_W=4.
- Sub-module rr_pick: combinational round-robin picker. Inputs are an eligibility mask and a start index; outputs are a one-hot grant and the index. Instantiated once.
- Top level holds the lock FSM, command register and read tracker.

## Test plan
- Reset with both requesters reading: all waitrequest 1, AVL_CS 0. After release, req0 granted first, then req1 (0,1,0,1…).
- req0 writes 0x0005_4A41 to 0x010 with BE 0xF while req1 reads 0x010 → write on AVL in N+1, read in N+2, req1 readdatavalid in N+4 with 0x0005_4A41.
- req1 only, 5 reads to 0x000–0x004 → 5 consecutive grants; 5 returns tagged id 1 in order.
- req1 asserts LOCK with continuous writes, req0 also writing, LOCK_MAX=4 → four req1 grants, then COOLDOWN, then req0 granted until req1 drops LOCK.
- req0 asserts READ and WRITE together to 0x800 → one write issued, no readdatavalid.
- RESET asserted one cycle after a read grant → no readdatavalid; after release, priority restarts at req0.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// vram_arbiter shared types and widths.
// Lock FSM states and Avalon slave field widths.
package vram_arb_pkg;

  localparam int AVL_ADDR_W = 12;
  localparam int AVL_DATA_W = 32;
  localparam int AVL_BE_W   = 4;

  typedef enum logic [1:0] {
    ARB      = 2'd0,
    LOCKED   = 2'd1,
    COOLDOWN = 2'd2
  } lock_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vram_arbiter_rr_pick.sv
// Combinational round-robin picker.
// First eligible requester at or after start wins.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // scan requesters in rotating order from start
  always_comb begin : pick
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!any && elig[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM slave port arbiter: round-robin, bounded lock,
// registered command and tagged read-return routing.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int READ_LATENCY = 2,
  parameter int LOCK_MAX     = 64
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NREQ-1:0]            REQ_READ,
  input  logic [NREQ-1:0]            REQ_WRITE,
  input  logic [NREQ-1:0]            REQ_LOCK,
  input  logic [NREQ*AVL_ADDR_W-1:0] REQ_ADDR,
  input  logic [NREQ*AVL_DATA_W-1:0] REQ_WRITEDATA,
  input  logic [NREQ*AVL_BE_W-1:0]   REQ_BYTE_EN,
  output logic [NREQ-1:0]            REQ_WAITREQUEST,
  output logic [AVL_DATA_W-1:0]      REQ_READDATA,
  output logic [NREQ-1:0]            REQ_READDATAVALID,
  output logic                       AVL_READ,
  output logic                       AVL_WRITE,
  output logic                       AVL_CS,
  output logic [AVL_ADDR_W-1:0]      AVL_ADDR,
  output logic [AVL_DATA_W-1:0]      AVL_WRITEDATA,
  output logic [AVL_BE_W-1:0]        AVL_BYTE_EN,
  input  logic [AVL_DATA_W-1:0]      AVL_READDATA
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam int D  = 1 + READ_LATENCY;

  lock_state_e   state, state_nxt;
  logic [IW-1:0] last_grant, last_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [CW-1:0] count, count_nxt, count_inc;

  logic [NREQ-1:0] active, owner_oh, elig;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx, start;
  logic            pick_any;
  logic            rd_sel, wr_sel;

  logic [D-1:0]         trk_v;
  logic [D-1:0][IW-1:0] trk_id;

  assign active    = REQ_READ | REQ_WRITE;
  assign owner_oh  = NREQ'(1) << owner;
  assign start     = (last_grant == IW'(NREQ - 1))
                   ? '0 : last_grant + 1'b1;
  assign count_inc = (count == CW'(LOCK_MAX))
                   ? count : count + CW'(1);

  // eligibility mask depends on lock tenure
  always_comb begin
    elig = active;
    case (state)
      LOCKED:   elig = active & owner_oh;
      COOLDOWN: elig = active & ~owner_oh;
      default:  elig = active;
    endcase
  end

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .elig  (elig),
    .start (start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign wr_sel = REQ_WRITE[pick_idx];
  assign rd_sel = REQ_READ[pick_idx] & ~wr_sel;

  assign REQ_WAITREQUEST = RESET ? '1 : ~pick_gnt;
  assign AVL_CS = AVL_READ | AVL_WRITE;

  // lock FSM next state, owner tracking and tenure count
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    count_nxt = count;
    last_nxt  = last_grant;
    if (pick_any) last_nxt = pick_idx;
    case (state)
      ARB: begin
        if (pick_any && REQ_LOCK[pick_idx]) begin
          owner_nxt = pick_idx;
          count_nxt = CW'(1);
          state_nxt = (LOCK_MAX <= 1) ? COOLDOWN : LOCKED;
        end
      end
      LOCKED: begin
        if (!REQ_LOCK[owner]) begin
          state_nxt = ARB;
          count_nxt = '0;
        end else if (pick_any) begin
          count_nxt = count_inc;
          if (count_inc == CW'(LOCK_MAX)) state_nxt = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (!REQ_LOCK[owner]) begin
          state_nxt = ARB;
          count_nxt = '0;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // arbitration state registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ARB;
      owner      <= '0;
      count      <= '0;
      last_grant <= IW'(NREQ - 1);
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      count      <= count_nxt;
      last_grant <= last_nxt;
    end
  end

  // register winning command onto the slave port
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AVL_READ      <= 1'b0;
      AVL_WRITE     <= 1'b0;
      AVL_ADDR      <= '0;
      AVL_WRITEDATA <= '0;
      AVL_BYTE_EN   <= '0;
    end else if (pick_any) begin
      AVL_READ      <= rd_sel;
      AVL_WRITE     <= wr_sel;
      AVL_ADDR      <=
        REQ_ADDR[int'(pick_idx)*AVL_ADDR_W +: AVL_ADDR_W];
      AVL_WRITEDATA <=
        REQ_WRITEDATA[int'(pick_idx)*AVL_DATA_W +: AVL_DATA_W];
      AVL_BYTE_EN   <=
        REQ_BYTE_EN[int'(pick_idx)*AVL_BE_W +: AVL_BE_W];
    end else begin
      AVL_READ  <= 1'b0;
      AVL_WRITE <= 1'b0;
    end
  end

  // read tracker: tag travels with slave latency
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      trk_v  <= '0;
      trk_id <= '0;
    end else begin
      trk_v[0]  <= pick_any & rd_sel;
      trk_id[0] <= pick_idx;
      for (int k = 1; k < D; k++) begin
        trk_v[k]  <= trk_v[k-1];
        trk_id[k] <= trk_id[k-1];
      end
    end
  end

  assign REQ_READDATAVALID = trk_v[D-1]
                           ? (NREQ'(1) << trk_id[D-1]) : '0;
  assign REQ_READDATA = trk_v[D-1] ? AVL_READDATA : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a VRAM slave model
// and a rotating-priority / lock-tenure reference model.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int RL   = 2;
  localparam int LM   = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  logic [NREQ-1:0]    REQ_READ, REQ_WRITE, REQ_LOCK;
  logic [NREQ*12-1:0] REQ_ADDR;
  logic [NREQ*32-1:0] REQ_WRITEDATA;
  logic [NREQ*4-1:0]  REQ_BYTE_EN;
  logic [NREQ-1:0]    REQ_WAITREQUEST, REQ_READDATAVALID;
  logic [31:0]        REQ_READDATA, AVL_READDATA;
  logic               AVL_READ, AVL_WRITE, AVL_CS;
  logic [11:0]        AVL_ADDR;
  logic [31:0]        AVL_WRITEDATA;
  logic [3:0]         AVL_BYTE_EN;

  logic        rd [NREQ];
  logic        wr [NREQ];
  logic        lk [NREQ];
  logic [11:0] ad [NREQ];
  logic [31:0] wd [NREQ];
  logic [3:0]  be [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_drv
    assign REQ_READ[i]  = rd[i];
    assign REQ_WRITE[i] = wr[i];
    assign REQ_LOCK[i]  = lk[i];
    assign REQ_ADDR[i*12 +: 12]      = ad[i];
    assign REQ_WRITEDATA[i*32 +: 32] = wd[i];
    assign REQ_BYTE_EN[i*4 +: 4]     = be[i];
  end

  vram_arbiter #(
    .NREQ(NREQ), .READ_LATENCY(RL), .LOCK_MAX(LM)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_READ(REQ_READ), .REQ_WRITE(REQ_WRITE),
    .REQ_LOCK(REQ_LOCK), .REQ_ADDR(REQ_ADDR),
    .REQ_WRITEDATA(REQ_WRITEDATA),
    .REQ_BYTE_EN(REQ_BYTE_EN),
    .REQ_WAITREQUEST(REQ_WAITREQUEST),
    .REQ_READDATA(REQ_READDATA),
    .REQ_READDATAVALID(REQ_READDATAVALID),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_CS(AVL_CS), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_READDATA(AVL_READDATA)
  );

  always #10 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // VRAM slave model: fixed read latency, byte-enabled writes
  logic [31:0] smem  [4096];
  logic [31:0] spipe [RL];
  always @(posedge CLK) begin
    if (AVL_WRITE)
      for (int b = 0; b < 4; b++)
        if (AVL_BYTE_EN[b])
          smem[AVL_ADDR][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
    spipe[0] <= AVL_READ ? smem[AVL_ADDR] : 32'hDEAD_BEEF;
    for (int k = 1; k < RL; k++) spipe[k] <= spipe[k-1];
  end
  assign AVL_READDATA = spipe[RL-1];

  typedef struct {
    int          due;
    logic        w;
    logic        r;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } cmd_t;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] d;
  } rd_t;

  cmd_t cq[$];
  rd_t  rq[$];

  logic [31:0] rmem [4096];

  int m_last, m_phase, m_owner, m_ten;

  task automatic model_reset();
    m_last  = NREQ - 1;
    m_phase = 0;
    m_owner = 0;
    m_ten   = 0;
  endtask

  function automatic int model_pick();
    int j;
    logic ok;
    for (int k = 1; k <= NREQ; k++) begin
      j  = (m_last + k) % NREQ;
      ok = rd[j] | wr[j];
      if (m_phase == 1 && j != m_owner) ok = 1'b0;
      if (m_phase == 2 && j == m_owner) ok = 1'b0;
      if (ok) return j;
    end
    return -1;
  endfunction

  task automatic step(output int dg);
    int w;
    cmd_t c;
    logic [NREQ-1:0] ew;
    @(negedge CLK); #1;
    w  = model_pick();
    ew = '1;
    if (w >= 0) ew[w] = 1'b0;
    chk("waitrequest", 64'(REQ_WAITREQUEST), 64'(ew));
    dg = -1;
    for (int i = 0; i < NREQ; i++)
      if (!REQ_WAITREQUEST[i]) dg = i;
    if (w >= 0) begin
      c.due = cyc + 1;
      c.w   = wr[w];
      c.r   = rd[w] & ~wr[w];
      c.a   = ad[w];
      c.d   = wd[w];
      c.be  = be[w];
      cq.push_back(c);
      if (c.w)
        for (int b = 0; b < 4; b++)
          if (be[w][b]) rmem[ad[w]][8*b +: 8] = wd[w][8*b +: 8];
      if (c.r)
        rq.push_back('{due: cyc + 1 + RL, id: w, d: rmem[ad[w]]});
      m_last = w;
    end
    case (m_phase)
      0: if (w >= 0 && lk[w]) begin
        m_owner = w;
        m_ten   = 1;
        m_phase = (m_ten >= LM) ? 2 : 1;
      end
      1: if (!lk[m_owner]) m_phase = 0;
         else if (w >= 0) begin
           m_ten++;
           if (m_ten >= LM) m_phase = 2;
         end
      default: if (!lk[m_owner]) m_phase = 0;
    endcase
    @(posedge CLK); #1;
    if (w >= 0) begin
      rd[w] = 1'b0;
      wr[w] = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    RESET = 1'b1;
    cq.delete();
    rq.delete();
    model_reset();
    for (int k = 0; k < n; k++) begin
      #1;
      chk("rst_waitreq", 64'(REQ_WAITREQUEST), 64'(2'b11));
      chk("rst_avl_cs", 64'(AVL_CS), 64'd0);
      chk("rst_avl_addr", 64'(AVL_ADDR), 64'd0);
      chk("rst_rdvalid", 64'(REQ_READDATAVALID), 64'd0);
      chk("rst_rddata", 64'(REQ_READDATA), 64'd0);
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic idle(input int n);
    int g;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        rd[i] = 1'b0;
        wr[i] = 1'b0;
      end
      step(g);
    end
  endtask

  // scoreboard monitor: slave commands and read returns
  initial begin
    cmd_t c;
    rd_t  r;
    logic [NREQ-1:0] oh;
    forever begin
      @(posedge CLK); #2;
      chk("avl_cs", 64'(AVL_CS), 64'(AVL_READ | AVL_WRITE));
      if (AVL_CS) begin
        if (cq.size() == 0) chk("avl_unexpected", 64'd1, 64'd0);
        else begin
          c = cq.pop_front();
          chk("avl_cycle", 64'(cyc), 64'(c.due));
          chk("avl_write", 64'(AVL_WRITE), 64'(c.w));
          chk("avl_read", 64'(AVL_READ), 64'(c.r));
          chk("avl_addr", 64'(AVL_ADDR), 64'(c.a));
          chk("avl_be", 64'(AVL_BYTE_EN), 64'(c.be));
          if (c.w) chk("avl_wdata", 64'(AVL_WRITEDATA), 64'(c.d));
        end
      end else if (cq.size() != 0 && cq[0].due <= cyc) begin
        void'(cq.pop_front());
        chk("avl_missing", 64'd0, 64'd1);
      end
      if (|REQ_READDATAVALID) begin
        if (rq.size() == 0) chk("rdv_unexpected", 64'd1, 64'd0);
        else begin
          r  = rq.pop_front();
          oh = '0;
          oh[r.id] = 1'b1;
          chk("rdv_cycle", 64'(cyc), 64'(r.due));
          chk("rdv_id", 64'(REQ_READDATAVALID), 64'(oh));
          chk("rdv_data", 64'(REQ_READDATA), 64'(r.d));
        end
      end else if (rq.size() != 0 && rq[0].due <= cyc) begin
        void'(rq.pop_front());
        chk("rdv_missing", 64'd0, 64'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int g;
  int exp_lock [12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    for (int a = 0; a < 4096; a++) begin
      smem[a] = '0;
      rmem[a] = '0;
    end
    for (int k = 0; k < RL; k++) spipe[k] = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd[i] = 1'b1; wr[i] = 1'b0; lk[i] = 1'b0;
      ad[i] = 12'(i); wd[i] = '0; be[i] = 4'hF;
    end
    model_reset();

    // both reading through reset, then strict alternation
    do_reset(3);
    for (int k = 0; k < 4; k++) begin
      rd[0] = 1'b1;
      rd[1] = 1'b1;
      step(g);
      chk("rr_alternate", 64'(g), 64'(k % 2));
    end
    idle(6);

    // write then read of the same word
    do_reset(1);
    wr[0] = 1'b1; ad[0] = 12'h010;
    wd[0] = 32'h0005_4A41; be[0] = 4'hF;
    rd[1] = 1'b1; ad[1] = 12'h010;
    step(g);
    chk("wr_first", 64'(g), 64'd0);
    step(g);
    chk("rd_second", 64'(g), 64'd1);
    idle(6);

    // single requester streaming reads
    for (int k = 0; k < 5; k++) begin
      rd[1] = 1'b1;
      ad[1] = 12'(k);
      step(g);
      chk("solo_grant", 64'(g), 64'd1);
    end
    idle(6);

    // bounded lock tenure and cooldown
    do_reset(1);
    lk[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 10) lk[1] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        wr[i] = 1'b1;
        ad[i] = 12'($urandom_range(0, 12'h257));
        wd[i] = $urandom;
        be[i] = 4'hF;
      end
      step(g);
      chk("lock_seq", 64'(g), 64'(exp_lock[k]));
    end
    idle(6);

    // read and write together resolve to a write
    do_reset(1);
    rd[0] = 1'b1; wr[0] = 1'b1;
    ad[0] = 12'h800; wd[0] = 32'h0000_00A5; be[0] = 4'h1;
    step(g);
    chk("rw_grant", 64'(g), 64'd0);
    idle(6);

    // reset right after a read grant discards it
    rd[0] = 1'b1; ad[0] = 12'h010;
    rd[1] = 1'b0; wr[1] = 1'b0;
    step(g);
    do_reset(2);
    rd[0] = 1'b1;
    rd[1] = 1'b1;
    step(g);
    chk("post_rst_prio", 64'(g), 64'd0);
    idle(6);

    // randomized traffic with lock toggling
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rd[i] && !wr[i] && $urandom_range(0, 9) < 6) begin
          int kind;
          kind  = $urandom_range(0, 19);
          rd[i] = (kind < 9) || (kind == 19);
          wr[i] = (kind >= 9);
          if ($urandom_range(0, 3) == 0)
            ad[i] = 12'h800 | 12'($urandom_range(0, 15));
          else if ($urandom_range(0, 1) == 0)
            ad[i] = 12'($urandom_range(0, 31));
          else
            ad[i] = 12'($urandom_range(0, 12'h257));
          wd[i] = $urandom;
          be[i] = 4'($urandom_range(1, 15));
        end
        if ($urandom_range(0, 15) == 0) lk[i] = ~lk[i];
      end
      step(g);
    end
    for (int i = 0; i < NREQ; i++) lk[i] = 1'b0;
    idle(8);

    chk("cmd_queue_empty", 64'(cq.size()), 64'd0);
    chk("rd_queue_empty", 64'(rq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
